tmds_serializer_multi: RTL and testbench
========================================

Name: tmds_serializer_multi

Overview:
- Parametrised successor to the fixed 3-lane, 1-bit-per-clock TMDS serializer.
- Serializes NUM_CH parallel TMDS words, SER_BITS bits per clock, plus a generated TMDS clock lane.
- Adds a ready/valid input with a one-word holding buffer, per-lane polarity inversion, selectable bit order, idle-token fill on underflow, and a pixel-rate load strobe that replaces the separate clock divider.
- Sits between the TMDS encoders and the pads or DDR output cells.

Parameters:
- NUM_CH, 3: number of data lanes.
- WORD_W, 10: parallel word width per lane.
- SER_BITS, 1: bits emitted per lane per clock. Must divide WORD_W with SLOTS = WORD_W/SER_BITS >= 2 (legal: 1, 2, 5).
- LSB_FIRST, 1: 1 transmits word bit 0 first; 0 transmits bit WORD_W-1 first.
- IDLE_WORD, 10'b1101010100: word loaded on every lane when no data is available (control token, hsync=vsync=0).

Ports:
- clk  in  1  serial-rate clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_data holds a valid set of words
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  NUM_CH*WORD_W  lane ch occupies bits [ch*WORD_W +: WORD_W]
- invert  in  NUM_CH  per-lane polarity invert, sampled at word load
- load_strobe  out  1  one-cycle pulse per word period; pixel-clock enable
- ser_out  out  NUM_CH*SER_BITS  lane ch at [ch*SER_BITS +: SER_BITS]
- ser_clk_out  out  SER_BITS  TMDS clock lane
- underflow  out  1  one-cycle pulse when IDLE_WORD is loaded after priming
- underflow_cnt  out  16  saturating count of underflow events

Behaviour:
- Slot counter: counts 0..SLOTS-1 and wraps to 0. Reset value 0. On the first cycle after reset deasserts, slot = 0.
- load_strobe = (slot == SLOTS-1). Never high during reset.
- Holding buffer: one entry (hold_data, hold_full).
  - in_ready = !reset && (!hold_full || slot == SLOTS-1), combinational.
  - Accept when in_valid && in_ready.
- Load, on the edge ending the slot == SLOTS-1 cycle. Each lane shift register loads one source, in this priority:
  1. hold_data, if hold_full.
  2. in_data directly (bypass), if hold is empty and an accept occurs in this same cycle.
  3. IDLE_WORD otherwise.
  - The loaded word is XOR-ed with {WORD_W{invert[ch]}}, then reversed if LSB_FIRST=0.
- Buffer update at the load edge:
  - If hold_full and accepting simultaneously, the new word replaces the consumed one and hold_full stays 1.
  - If hold_full with no accept, hold_full clears.
  - If bypassing, hold_full stays 0.
- Buffer update at a non-load edge: an accept sets hold_full and captures the word.
- Shifting: every non-load edge shifts each lane register right by SER_BITS.
  - ser_out lane ch = the low SER_BITS bits of that lane's register (registered output).
  - Within a cycle, bit k of a lane carries transmit-order bit slot*SER_BITS + k.
- Clock lane: loads the constant pattern of WORD_W/2 ones followed by WORD_W/2 zeros (transmit order) at every load edge, and shifts identically to the data lanes. It is never inverted.
- Latency: a word accepted in the slot == SLOTS-1 cycle (bypass) appears on ser_out on the next cycle. A word accepted earlier waits in hold until the next load edge.
- Priming and underflow:
  - primed is set by the first accept after reset.
  - underflow pulses on a load edge that takes source 3 while primed.
  - underflow_cnt increments on each pulse and saturates at 16'hFFFF.
  - Idle fill before priming is not counted.
- Reset values: all shift registers 0, ser_out 0, ser_clk_out 0, hold_full 0, primed 0, underflow 0, underflow_cnt 0.
- Reset mid-word: takes effect on the next edge. The partial word is discarded, no underflow is counted, and the buffered word is dropped.
- invert changes between loads have no effect until the next load.

Test Plan:
- SER_BITS=1, LSB_FIRST=1: present 10'h2AA on lane 0 at slot 9 with in_valid=1 -> in_ready=1; ser_out[0] over the next 10 cycles = 0,1,0,1,0,1,0,1,0,1; ser_clk_out = 1,1,1,1,1,0,0,0,0,0; load_strobe high on every 10th cycle.
- SER_BITS=2: clock lane -> ser_clk_out = 2'b11, 2'b11, 2'b01, 2'b00, 2'b00, repeating; lane 0 with 10'h3FF and invert[0]=1 -> ser_out lane 0 = 2'b00 throughout.
- Backpressure: hold in_valid=1 continuously, with a new word on every accept -> in_ready is low from the cycle after the first accept until each slot 9 cycle; exactly one accept per word period; no word lost or repeated.
- Underflow: after one accepted word, drop in_valid for 3 word periods -> underflow pulses 3 times, underflow_cnt=3, and lanes carry 1101010100 in transmit order (LSB_FIRST=1: 0,0,1,0,1,0,1,0,1,1). Before any accept, idle fill leaves underflow_cnt=0.
- LSB_FIRST=0 with word 10'h001 -> lane emits nine 0s then one 1.
- Reset asserted at slot 4 with a word buffered -> the next cycle shows slot=0, ser_out=0, hold empty and in_ready low while reset is high; after release, the first load at slot 9 is idle with underflow_cnt unchanged.

Source files
------------

// File: rtl/tmds_serializer_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_serializer_multi
//  Brief    : NUM_CH-lane TMDS serializer, SER_BITS bits per clock, with
//             ready/valid holding buffer, idle fill and generated clock lane.
//  Revision : 1.0
// ============================================================================
module tmds_serializer_multi #(
    parameter int                NUM_CH    = 3,
    parameter int                WORD_W    = 10,
    parameter int                SER_BITS  = 1,
    parameter int                LSB_FIRST = 1,
    parameter logic [WORD_W-1:0] IDLE_WORD = 10'b1101010100
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*WORD_W-1:0]     in_data,
    input  logic [NUM_CH-1:0]            invert,
    output logic                         load_strobe,
    output logic [NUM_CH*SER_BITS-1:0]   ser_out,
    output logic [SER_BITS-1:0]          ser_clk_out,
    output logic                         underflow,
    output logic [15:0]                  underflow_cnt
);

    localparam int                  c_slots       = WORD_W / SER_BITS;
    localparam int                  c_slot_w      = $clog2(c_slots);
    localparam logic [c_slot_w-1:0] c_last_slot   = c_slot_w'(c_slots - 1);
    // Register bit i holds transmit-order bit i: ones go out first.
    localparam logic [WORD_W-1:0]   c_clk_pattern = {{(WORD_W - WORD_W/2){1'b0}}, {(WORD_W/2){1'b1}}};

    logic [c_slot_w-1:0]      r_slot;
    logic [NUM_CH*WORD_W-1:0] r_hold_data;
    logic                     r_hold_full;
    logic                     r_primed;
    logic                     r_underflow;
    logic [15:0]              r_underflow_cnt;
    logic [WORD_W-1:0]        r_clk_sr;

    logic w_load;
    logic w_ready;
    logic w_accept;

    assign w_load   = (r_slot == c_last_slot);
    assign w_ready  = !reset && (!r_hold_full || w_load);
    assign w_accept = in_valid && w_ready;

    assign in_ready      = w_ready;
    assign load_strobe   = w_load && !reset;
    assign underflow     = r_underflow;
    assign underflow_cnt = r_underflow_cnt;
    assign ser_clk_out   = r_clk_sr[SER_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot          <= '0;
            r_hold_data     <= '0;
            r_hold_full     <= 1'b0;
            r_primed        <= 1'b0;
            r_underflow     <= 1'b0;
            r_underflow_cnt <= '0;
            r_clk_sr        <= '0;
        end else begin
            r_slot      <= w_load ? '0 : r_slot + 1'b1;
            r_primed    <= r_primed | w_accept;
            r_underflow <= 1'b0;
            if (w_accept && (r_hold_full || !w_load)) begin
                r_hold_data <= in_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
            if (w_load) begin
                r_clk_sr <= c_clk_pattern;
                // Idle fill only counts once real traffic has started.
                if (!r_hold_full && !w_accept && r_primed) begin
                    r_underflow <= 1'b1;
                    if (r_underflow_cnt != 16'hFFFF)
                        r_underflow_cnt <= r_underflow_cnt + 16'd1;
                end
            end else begin
                r_clk_sr <= r_clk_sr >> SER_BITS;
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
        logic [WORD_W-1:0] w_src;
        logic [WORD_W-1:0] w_inv;
        logic [WORD_W-1:0] w_word;
        logic [WORD_W-1:0] r_sh;

        always_comb begin
            w_src = IDLE_WORD;
            if (r_hold_full)
                w_src = r_hold_data[ch*WORD_W +: WORD_W];
            else if (w_accept)
                w_src = in_data[ch*WORD_W +: WORD_W];
            w_inv  = w_src ^ {WORD_W{invert[ch]}};
            w_word = w_inv;
            if (LSB_FIRST == 0) begin
                for (int b = 0; b < WORD_W; b++)
                    w_word[b] = w_inv[WORD_W-1-b];
            end
        end

        always_ff @(posedge clk) begin
            if (reset)
                r_sh <= '0;
            else if (w_load)
                r_sh <= w_word;
            else
                r_sh <= r_sh >> SER_BITS;
        end

        assign ser_out[ch*SER_BITS +: SER_BITS] = r_sh[SER_BITS-1:0];
    end

endmodule
`default_nettype wire

// File: tb/tb_tmds_serializer_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmds_serializer_multi
//  Brief    : Directed self-checking bench for tmds_serializer_multi.
//  Revision : 1.0
// ============================================================================
module tb_tmds_serializer_multi;

    localparam logic [9:0] c_idle = 10'b1101010100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Default instance: SER_BITS=1, LSB_FIRST=1
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] in_data = '0;
    logic [2:0]  invert = '0;
    logic        load_strobe;
    logic [2:0]  ser_out;
    logic [0:0]  ser_clk_out;
    logic        underflow;
    logic [15:0] underflow_cnt;

    tmds_serializer_multi dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .invert(invert), .load_strobe(load_strobe),
        .ser_out(ser_out), .ser_clk_out(ser_clk_out), .underflow(underflow),
        .underflow_cnt(underflow_cnt)
    );

    // SER_BITS=2 instance
    logic        v2 = 1'b0;
    logic        rdy2;
    logic [29:0] d2 = '0;
    logic [2:0]  inv2 = '0;
    logic        ls2;
    logic [5:0]  so2;
    logic [1:0]  sc2;
    logic        uf2;
    logic [15:0] ufc2;

    tmds_serializer_multi #(.SER_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2),
        .in_data(d2), .invert(inv2), .load_strobe(ls2),
        .ser_out(so2), .ser_clk_out(sc2), .underflow(uf2),
        .underflow_cnt(ufc2)
    );

    // MSB-first instance
    logic        v3 = 1'b0;
    logic        rdy3;
    logic [29:0] d3 = '0;
    logic [2:0]  inv3 = '0;
    logic        ls3;
    logic [2:0]  so3;
    logic [0:0]  sc3;
    logic        uf3;
    logic [15:0] ufc3;

    tmds_serializer_multi #(.LSB_FIRST(0)) dut3 (
        .clk(clk), .reset(reset), .in_valid(v3), .in_ready(rdy3),
        .in_data(d3), .invert(inv3), .load_strobe(ls3),
        .ser_out(so3), .ser_clk_out(sc3), .underflow(uf3),
        .underflow_cnt(ufc3)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [9:0] wv(input int n);
        return 10'(n * 77 + 45);
    endfunction

    task automatic wait_strobe(input int which);
        int  n = 0;
        logic s;
        s = (which == 2) ? ls2 : ls3;
        while (!s && n < 25) begin
            tick();
            #1;
            s = (which == 2) ? ls2 : ls3;
            n++;
        end
        checks++;
        if (!s) begin
            errors++;
            $display("FAIL wait_strobe%0d: load_strobe=%b after %0d cycles, required 1", which, s, n);
        end
    endtask

    task automatic test_reset();
        tick(); tick(); tick();
        #1;
        checks++;
        if (ser_out !== 3'b000 || ser_clk_out !== 1'b0 || in_ready !== 1'b0 ||
            load_strobe !== 1'b0 || underflow_cnt !== 16'd0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ser=%b clk=%b rdy=%b ls=%b cnt=%0d uf=%b, required all 0",
                     ser_out, ser_clk_out, in_ready, load_strobe, underflow_cnt, underflow);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (load_strobe !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: ls=%b rdy=%b, required 0 1", load_strobe, in_ready);
        end
        for (int i = 1; i <= 9; i++) begin
            tick();
            #1;
            checks++;
            if (load_strobe !== (i == 9)) begin
                errors++;
                $display("FAIL first_period ls i=%0d: got %b, required %b", i, load_strobe, i == 9);
            end
        end
        // One unprimed idle period: idle pattern out, nothing counted.
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            checks++;
            if (ser_out[0] !== c_idle[i] || underflow !== 1'b0 || underflow_cnt !== 16'd0) begin
                errors++;
                $display("FAIL unprimed_idle i=%0d: ser=%b uf=%b cnt=%0d, required %b 0 0",
                         i, ser_out[0], underflow, underflow_cnt, c_idle[i]);
            end
        end
    endtask

    task automatic test_basic();
        in_valid = 1'b1;
        in_data  = {10'h000, 10'h3FF, 10'h2AA};
        #1;
        checks++;
        if (in_ready !== 1'b1 || load_strobe !== 1'b1) begin
            errors++;
            $display("FAIL basic_accept: rdy=%b ls=%b, required 1 1", in_ready, load_strobe);
        end
        for (int i = 0; i < 10; i++) begin
            logic [9:0] w;
            w = 10'h2AA;
            tick();
            in_valid = 1'b0;
            #1;
            checks++;
            if (ser_out !== {1'b0, 1'b1, w[i]} || ser_clk_out !== 1'(i < 5) ||
                load_strobe !== (i == 9)) begin
                errors++;
                $display("FAIL basic i=%0d: ser=%b clk=%b ls=%b, required %b %b %b",
                         i, ser_out, ser_clk_out, load_strobe, {1'b0, 1'b1, w[i]}, i < 5, i == 9);
            end
        end
    endtask

    task automatic test_underflow();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 10; i++) begin
                tick();
                #1;
                checks++;
                if (ser_out[0] !== c_idle[i] || underflow !== (i == 0) ||
                    underflow_cnt !== 16'(p + 1)) begin
                    errors++;
                    $display("FAIL underflow p=%0d i=%0d: ser=%b uf=%b cnt=%0d, required %b %b %0d",
                             p, i, ser_out[0], underflow, underflow_cnt, c_idle[i], i == 0, p + 1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int   k = 1;
        logic acc_prev;
        in_valid = 1'b1;
        in_data  = {20'h0, wv(0)};
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: rdy=%b, required 1", in_ready);
        end
        acc_prev = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 10; i++) begin
                logic       exp_rdy;
                logic [9:0] w;
                tick();
                if (acc_prev) begin
                    in_data = {20'h0, wv(k)};
                    k++;
                end
                #1;
                exp_rdy = (p == 0 && i == 0) || i == 9;
                w = wv(p);
                checks++;
                if (in_ready !== exp_rdy || ser_out[0] !== w[i] || underflow !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b p=%0d i=%0d: rdy=%b ser=%b uf=%b, required %b %b 0",
                             p, i, in_ready, ser_out[0], underflow, exp_rdy, w[i]);
                end
                acc_prev = exp_rdy;
            end
        end
    endtask

    task automatic test_reset_mid_word();
        for (int i = 0; i <= 4; i++) begin
            tick();
            in_valid = 1'b0;
        end
        #1;
        checks++;
        if (dut.r_hold_full !== 1'b1) begin
            errors++;
            $display("FAIL mid_hold_before: hold_full=%b, required 1", dut.r_hold_full);
        end
        reset = 1'b1;
        tick();
        #1;
        checks++;
        if (dut.r_slot !== 4'd0 || ser_out !== 3'b000 || ser_clk_out !== 1'b0 ||
            dut.r_hold_full !== 1'b0 || in_ready !== 1'b0 || load_strobe !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: slot=%0d ser=%b clk=%b hold=%b rdy=%b ls=%b, required 0 000 0 0 0 0",
                     dut.r_slot, ser_out, ser_clk_out, dut.r_hold_full, in_ready, load_strobe);
        end
        reset = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        #1;
        checks++;
        if (load_strobe !== 1'b1) begin
            errors++;
            $display("FAIL mid_slot9: ls=%b, required 1", load_strobe);
        end
        tick();
        #1;
        checks++;
        if (underflow !== 1'b0 || underflow_cnt !== 16'd0 || ser_out[0] !== c_idle[0] ||
            ser_clk_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_after: uf=%b cnt=%0d ser=%b clk=%b, required 0 0 %b 1",
                     underflow, underflow_cnt, ser_out[0], ser_clk_out, c_idle[0]);
        end
    endtask

    task automatic test_ser2();
        logic [1:0] c_tab [5] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
        wait_strobe(2);
        v2   = 1'b1;
        d2   = {10'h000, 10'h3FF, 10'h3FF};
        inv2 = 3'b001;
        #1;
        checks++;
        if (rdy2 !== 1'b1) begin
            errors++;
            $display("FAIL ser2_accept: rdy=%b, required 1", rdy2);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            v2 = 1'b0;
            #1;
            checks++;
            if (sc2 !== c_tab[i % 5] || (i < 5 && (so2[1:0] !== 2'b00 || so2[3:2] !== 2'b11))) begin
                errors++;
                $display("FAIL ser2 i=%0d: clk=%b lane0=%b lane1=%b, required %b 00 11",
                         i, sc2, so2[1:0], so2[3:2], c_tab[i % 5]);
            end
        end
    endtask

    task automatic test_msb_first();
        wait_strobe(3);
        v3 = 1'b1;
        d3 = {20'h0, 10'h001};
        tick();
        v3 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            #1;
            checks++;
            if (so3[0] !== (i == 9) || so3[2:1] !== 2'b00) begin
                errors++;
                $display("FAIL msb_first i=%0d: lane0=%b lanes21=%b, required %b 00",
                         i, so3[0], so3[2:1], i == 9);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_back_to_back();
        test_reset_mid_word();
        test_ser2();
        test_msb_first();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
